// File: rtl/relu_layer_sequencer.sv
// relu_layer_sequencer
//
// Runs NEURONS two-input ReLU neurons one after another on a single shared
// pipelined multiplier (multFPU) and a single shared adder (addFPU). Each
// neuron computes relu(x*wx + y*wy + bias). The weights and biases live in a
// register file that is loaded over a simple config port.
//
// Optional feature: define RELU_SEQ_ABORT_EN to add the `abort` input, which
// stops a running computation and throws away its partial results.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     input (x_in, y_in) handshake
//   out_valid/out_ready   output handshake, out_data slot k = bits [32k+31:32k]
//   cfg_we/addr/wdata     register-file write port (addr 3k=wx, 3k+1=wy, 3k+2=bias)
//   cfg_err               one-cycle pulse after a dropped write
//   mul_a/mul_b/mul_q     shared multiplier, result MUL_LAT cycles after issue
//   add_a/add_b/add_q     shared adder, result ADD_LAT cycles after issue
//   abort                 (RELU_SEQ_ABORT_EN only) cancel the running computation
//   dbg_state             current sequencer state
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready is 1 only when idle with no result waiting, so an
// input pair and an output beat never overlap. Once out_valid is 1 it stays
// 1, with out_data stable, until the edge where out_ready is 1.
module relu_layer_sequencer #(
  parameter int          NEURONS  = 3,
  parameter int          MUL_LAT  = 3,
  parameter int          ADD_LAT  = 2,
  parameter logic [31:0] INIT_VAL = 32'h4019999a
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           x_in,
  input  logic [31:0]           y_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NEURONS-1:0] out_data,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic                  cfg_err,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_q,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  input  logic [31:0]           add_q,
`ifdef RELU_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic [3:0]            dbg_state
);

  // Cycles spent on one neuron, from its MUL0 cycle to its STORE cycle.
  localparam int T    = 4 + MUL_LAT + 2 * ADD_LAT;
  localparam int CW   = $clog2(T);
  localparam int RF_N = 3 * NEURONS;
  localparam int AW   = (RF_N > 1) ? $clog2(RF_N) : 1;
  localparam int NIW  = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  // Cycle indices within a neuron where the FPU results are captured.
  localparam logic [CW-1:0] C_P0   = CW'(MUL_LAT);
  localparam logic [CW-1:0] C_P1   = CW'(MUL_LAT + 1);
  localparam logic [CW-1:0] C_ADD0 = CW'(MUL_LAT + 2);
  localparam logic [CW-1:0] C_SUM  = CW'(MUL_LAT + 2 + ADD_LAT);
  localparam logic [CW-1:0] C_ADD1 = CW'(MUL_LAT + 3 + ADD_LAT);
  localparam logic [CW-1:0] C_LAST = CW'(T - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_MUL0,
    S_MUL1,
    S_MWAIT,
    S_ADD0,
    S_AWAIT0,
    S_ADD1,
    S_AWAIT1,
    S_STORE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [NIW-1:0]   nidx_q, nidx_d;

  logic [31:0]      x_q, y_q;
  logic [31:0]      p0_q, p1_q, sum_q;
  logic [31:0]      stage [NEURONS];
  logic [31:0]      rf [RF_N];
  logic             init_done;

  logic             accept;
  logic             busy;
  logic             last_neuron;
  logic             abort_hit;
  logic             store_fire;
  logic             cfg_ok;
  logic [31:0]      relu_q;
  logic [AW-1:0]    rf_base;

  // The phase within a neuron follows from the cycle index alone, so the
  // state and the counter can never disagree. MWAIT, AWAIT0 and AWAIT1 may be
  // short or empty for small latencies; the capture points use cyc_q, not the
  // state, so they stay correct in that case.
  function automatic state_t phase_of(input logic [CW-1:0] c);
    if (c == '0)                 return S_MUL0;
    else if (c == CW'(1))        return S_MUL1;
    else if (c < C_ADD0)         return S_MWAIT;
    else if (c == C_ADD0)        return S_ADD0;
    else if (c < C_ADD1)         return S_AWAIT0;
    else if (c == C_ADD1)        return S_ADD1;
    else if (c < C_LAST)         return S_AWAIT1;
    else                         return S_STORE;
  endfunction

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = init_done && !busy && !out_valid;
  assign accept      = in_valid && in_ready;
  assign last_neuron = (nidx_q == NIW'(NEURONS - 1));
  assign rf_base     = AW'(nidx_q) * AW'(3);
  assign relu_q      = add_q[31] ? 32'h0 : add_q;   // -0.0 also maps to +0
  assign store_fire  = (state_q == S_STORE) && !abort_hit;
  assign dbg_state   = state_q;

`ifdef RELU_SEQ_ABORT_EN
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  // Writes are only safe while nothing reads the file, so they are refused
  // while busy and on the very edge that starts a computation.
  assign cfg_ok = cfg_we && !busy && !accept && (cfg_addr < 5'(RF_N));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      nidx_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      nidx_q  <= nidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    nidx_d  = nidx_q;
    if (!busy) begin
      if (accept) begin
        state_d = S_MUL0;
        cyc_d   = '0;
        nidx_d  = '0;
      end
    end else if (abort_hit) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      nidx_d  = '0;
    end else if (cyc_q == C_LAST) begin
      cyc_d = '0;
      if (last_neuron) begin
        state_d = S_IDLE;
        nidx_d  = '0;
      end else begin
        state_d = S_MUL0;
        nidx_d  = nidx_q + NIW'(1);
      end
    end else begin
      cyc_d   = cyc_q + CW'(1);
      state_d = phase_of(cyc_q + CW'(1));
    end
  end

  // FPU operands are issued only in the four issue states, zero otherwise.
  always_comb begin
    mul_a = 32'h0;
    mul_b = 32'h0;
    add_a = 32'h0;
    add_b = 32'h0;
    case (state_q)
      S_MUL0: begin
        mul_a = x_q;
        mul_b = rf[rf_base];
      end
      S_MUL1: begin
        mul_a = y_q;
        mul_b = rf[rf_base + AW'(1)];
      end
      S_ADD0: begin
        add_a = p0_q;
        add_b = p1_q;
      end
      S_ADD1: begin
        add_a = sum_q;
        add_b = rf[rf_base + AW'(2)];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q   <= 32'h0;
      y_q   <= 32'h0;
      p0_q  <= 32'h0;
      p1_q  <= 32'h0;
      sum_q <= 32'h0;
      for (int k = 0; k < NEURONS; k++) stage[k] <= 32'h0;
    end else begin
      if (accept) begin
        x_q <= x_in;
        y_q <= y_in;
      end
      if (busy && cyc_q == C_P0)  p0_q  <= mul_q;
      if (busy && cyc_q == C_P1)  p1_q  <= mul_q;
      if (busy && cyc_q == C_SUM) sum_q <= add_q;
      if (store_fire) stage[nidx_q] <= relu_q;
    end
  end

  // ---------------------------------------------------------------- register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RF_N; i++) rf[i] <= INIT_VAL;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_ok) rf[cfg_addr[AW-1:0]] <= cfg_wdata;
      cfg_err <= cfg_we && !cfg_ok;
    end
  end

  // ---------------------------------------------------------------- output beat
  // out_data is loaded only when the last neuron stores, so an aborted or
  // reset run never leaves a partial result visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (store_fire && last_neuron) begin
        out_valid <= 1'b1;
        for (int k = 0; k < NEURONS - 1; k++) out_data[32*k +: 32] <= stage[k];
        out_data[32*(NEURONS-1) +: 32] <= relu_q;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Testbench for relu_layer_sequencer with default parameters. The bench
// provides floating-point multiplier/adder models with the exact latencies,
// keeps a transaction-level reference of the layer, and checks the outputs
// every cycle plus a set of hand-computed values.
module tb_relu_layer_sequencer;

  localparam int N  = 3;
  localparam int ML = 3;
  localparam int AL = 2;
  localparam int T  = 4 + ML + 2 * AL;
  localparam int W  = 32 * N;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   x_in = '0, y_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          cfg_err;
  logic [31:0]   mul_a, mul_b, mul_q, add_a, add_b, add_q;
  logic [3:0]    dbg_state;
`ifdef RELU_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  relu_layer_sequencer #(.NEURONS(N), .MUL_LAT(ML), .ADD_LAT(AL)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_q(mul_q),
    .add_a(add_a), .add_b(add_b), .add_q(add_q),
`ifdef RELU_SEQ_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- float helpers
  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 127) begin r = r * 2.0; e--; end
    while (e < 127) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  // Round a double to single precision, nearest-even (normal range only).
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rest;
    int          e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'h0;
    e    = int'(d[62:52]) - 896;
    m    = {2'b01, d[51:29]};
    rest = d[28:0];
    if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e++; end
    return {d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rand_float();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)), 23'($urandom)};
  endfunction

  // ---------------------------------------------------------------- FPU models
  logic [31:0] mpipe [1:ML];
  logic [31:0] apipe [1:AL];
  always @(posedge clk) begin
    mpipe[1] <= fmul(mul_a, mul_b);
    for (int k = 2; k <= ML; k++) mpipe[k] <= mpipe[k-1];
    apipe[1] <= fadd(add_a, add_b);
    for (int k = 2; k <= AL; k++) apipe[k] <= apipe[k-1];
  end
  assign mul_q = mpipe[ML];
  assign add_q = apipe[AL];

  // ---------------------------------------------------------------- reference model
  logic [31:0]  m_rf [3*N];
  logic         m_busy, m_out_valid, m_in_ready, m_cfg_err;
  int           m_cnt;
  logic [W-1:0] m_out_data;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] layer(input logic [31:0] x, input logic [31:0] y);
    logic [W-1:0] v;
    logic [31:0]  o;
    v = '0;
    for (int k = 0; k < N; k++) begin
      o = fadd(fadd(fmul(x, m_rf[3*k]), fmul(y, m_rf[3*k+1])), m_rf[3*k+2]);
      v[32*k +: 32] = o[31] ? 32'h0 : o;
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    logic acc, ok, aborted;
    if (!reset) begin
      m_busy = 0; m_out_valid = 0; m_in_ready = 0; m_cfg_err = 0; m_cnt = 0;
      m_out_data = '0;
      for (int i = 0; i < 3*N; i++) m_rf[i] = 32'h4019999a;
      exp_q.delete();
    end else begin
      acc       = in_valid && m_in_ready;
      ok        = cfg_we && !m_busy && !acc && (int'(cfg_addr) < 3*N);
      m_cfg_err = cfg_we && !ok;
      if (ok) m_rf[cfg_addr] = cfg_wdata;
      if (m_busy) begin
        aborted = 0;
`ifdef RELU_SEQ_ABORT_EN
        aborted = abort;
`endif
        if (aborted) begin
          m_busy = 0;
          exp_q.delete();
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy      = 0;
            m_out_valid = 1;
            m_out_data  = exp_q.pop_front();
          end
        end
      end else if (m_out_valid && out_ready) begin
        m_out_valid = 0;
      end
      if (acc) begin
        exp_q.push_back(layer(x_in, y_in));
        m_busy = 1;
        m_cnt  = N * T;
      end
      m_in_ready = !m_busy && !m_out_valid;
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready",  W'(in_ready),  W'(m_in_ready));
    check("out_valid", W'(out_valid), W'(m_out_valid));
    check("cfg_err",   W'(cfg_err),   W'(m_cfg_err));
    check("out_data",  out_data,      m_out_data);
    if (!m_busy) begin
      check("mul_a_idle", W'(mul_a), '0);
      check("mul_b_idle", W'(mul_b), '0);
      check("add_a_idle", W'(add_a), '0);
      check("add_b_idle", W'(add_b), '0);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  int acc_cyc;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_addr = 5'($urandom); cfg_wdata = $urandom;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int  i;
    bit  done;
    in_valid = 1'b1; x_in = x; y_in = y;
    i = 0; done = 0;
    while (!done && i < 200) begin
      if (in_ready) done = 1;
      tick();
      i++;
    end
    in_valid = 1'b0; x_in = $urandom; y_in = $urandom;
    acc_cyc = cyc_cnt;
    if (!done) check("accept_timeout", W'(1), W'(0));
  endtask

  task automatic wait_out(output int lat);
    int i;
    i = 0;
    while (!out_valid && i < 500) begin tick(); i++; end
    lat = cyc_cnt - acc_cyc;
    if (!out_valid) check("out_valid_timeout", W'(0), W'(1));
  endtask

  task automatic drain(input int hold, input bit poke);
    out_ready = 1'b0;
    repeat (hold) begin
      in_valid = poke; x_in = $urandom; y_in = $urandom;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  localparam logic [W-1:0] S1_RES = {3{32'h40E66667}};
  localparam logic [W-1:0] S2_RES = {32'h40E66667, 32'h0, 32'h40E66667};
  localparam logic [W-1:0] S3_RES = {3{32'h40000000}};

  initial begin
    int lat;
    logic [31:0] hold_data;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  W'(in_ready),  '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data",  out_data,      '0);
    check("rst_cfg_err",   W'(cfg_err),   '0);
    #1 reset = 1'b1;
    tick();
    check("ready_after_rst", W'(in_ready), W'(1));

    // 1: default weights, x = y = 1.0; then 4: hold output 20 cycles
    send(32'h3f800000, 32'h3f800000);
    wait_out(lat);
    check("s1_latency", W'(lat), W'(33));
    check("s1_result",  out_data, S1_RES);
    drain(20, 1'b1);
    check("s4_out_valid_fell", W'(out_valid), '0);
    check("s4_in_ready_rose",  W'(in_ready),  W'(1));
    check("s4_data_held",      out_data,      S1_RES);

    // 2: bias of neuron 1 = -10.0
    cfg_write(5'd5, 32'hC1200000);
    send(32'h3f800000, 32'h3f800000);
    wait_out(lat);
    check("s2_result", out_data, S2_RES);
    drain(0, 1'b0);

    // 5: out-of-range write while idle, write while busy
    cfg_write(5'd9, 32'h12345678);
    check("s5_err_range", W'(cfg_err), W'(1));
    tick();
    check("s5_err_clear", W'(cfg_err), '0);
    send(32'h3f800000, 32'h3f800000);
    repeat (4) tick();
    cfg_write(5'd0, 32'h3F800000);
    check("s5_err_busy", W'(cfg_err), W'(1));
    wait_out(lat);
    check("s5_result", out_data, S2_RES);
    drain(2, 1'b0);

    // 3: all weights and biases = 1.0, x = 0, y = 1
    for (int a = 0; a < 3*N; a++) cfg_write(5'(a), 32'h3F800000);
    send(32'h00000000, 32'h3f800000);
    wait_out(lat);
    check("s3_result", out_data, S3_RES);
    drain(1, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      repeat ($urandom_range(0, 4)) cfg_write(5'($urandom_range(0, 10)), rand_float());
      repeat ($urandom_range(0, 3)) tick();
      send(rand_float(), rand_float());
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 20)) tick();
        cfg_write(5'($urandom_range(0, 8)), rand_float());
      end
      wait_out(lat);
      check("rand_latency", W'(lat), W'(N * T));
      drain($urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    // 6: reset in the middle of a computation
    send(32'h3f800000, 32'h3f800000);
    repeat (15) tick();
    reset = 1'b0;
    #1;
    check("s6_out_valid", W'(out_valid), '0);
    check("s6_in_ready",  W'(in_ready),  '0);
    check("s6_out_data",  out_data,      '0);
    check("s6_cfg_err",   W'(cfg_err),   '0);
    check("s6_mul_a",     W'(mul_a),     '0);
    check("s6_add_b",     W'(add_b),     '0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    send(32'h3f800000, 32'h3f800000);
    wait_out(lat);
    check("s6_latency", W'(lat), W'(33));
    check("s6_result",  out_data, S1_RES);
    drain(0, 1'b0);

`ifdef RELU_SEQ_ABORT_EN
    // Abort at cycle 10 of a computation
    send(32'h3f800000, 32'h40000000);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_next", W'(in_ready), W'(1));
    repeat (40) tick();
    check("abort_no_valid", W'(out_valid), '0);
    check("abort_data_kept", out_data, S1_RES);
    // Abort while idle and while a result waits has no effect
    abort = 1'b1;
    tick();
    abort = 1'b0;
    send(32'h3f800000, 32'h3f800000);
    wait_out(lat);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_hold_valid", W'(out_valid), W'(1));
    check("abort_hold_data",  out_data, S1_RES);
    drain(0, 1'b0);
`endif

    repeat (3) tick();
    hold_data = out_data[31:0];
    check("final_slot0", W'(hold_data), W'(32'h40E66667));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/relu_layer_sequencer.md
Name: relu_layer_sequencer

Overview:
- Time-multiplexes one shared pipelined multFPU and one shared addFPU across NEURONS two-input ReLU neurons. Replaces the per-neuron FPU instances of the ReLU layer.
- Holds a weight/bias register file, writable over a config port.
- Accepts one (x, y) float pair through a valid/ready handshake, computes every neuron serially, then presents all results together as one output beat.

Parameters:
- NEURONS, 3, neuron count. Must be 1..8.
- MUL_LAT, 3, multFPU latency in cycles from operand cycle to q valid. Must be ≥1.
- ADD_LAT, 2, addFPU latency in cycles. Must be ≥1.
- INIT_VAL, 32'h4019999a, reset value of every weight and bias (2.4).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- in_valid  in  1  input pair valid
- in_ready  out  1  sequencer can accept an input pair
- x_in  in  32  IEEE-754 single-precision x
- y_in  in  32  IEEE-754 single-precision y
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- out_data  out  32*NEURONS  neuron k result at bits [32k+31:32k]
- cfg_we  in  1  register-file write strobe
- cfg_addr  in  5  register-file address
- cfg_wdata  in  32  register-file write data
- cfg_err  out  1  one-cycle pulse when a write is dropped
- mul_a, mul_b  out  32  multFPU operands
- mul_q  in  32  multFPU result
- add_a, add_b  out  32  addFPU operands
- add_q  in  32  addFPU result

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=0 while reset is asserted, 1 on the first cycle after release.
  - out_valid=0, out_data=0, cfg_err=0, all FPU operands=0.
  - All register-file entries = INIT_VAL.
  - Reset mid-computation aborts the computation; partial results are discarded.
- Register-file map:
  - Neuron k: addr 3k = wx, 3k+1 = wy, 3k+2 = bias.
  - Write takes effect at the clk edge when cfg_we=1.
  - Write is dropped with a cfg_err pulse on the next cycle if state≠IDLE or addr≥3*NEURONS.
  - A write at the same edge as input acceptance is dropped and flagged.
- Input handshake:
  - in_ready = (state==IDLE) && !out_valid.
  - Acceptance edge: in_valid && in_ready. x_in and y_in are latched; state becomes MUL0 for neuron 0.
- Per-neuron schedule, T = 4+MUL_LAT+2*ADD_LAT cycles, cycle index c relative to the neuron's MUL0 cycle:
  - c=0, MUL0: mul_a=x, mul_b=wx.
  - c=1, MUL1: mul_a=y, mul_b=wy.
  - c=2..MUL_LAT+1, MWAIT: p0 captured from mul_q at c=MUL_LAT; p1 captured at c=MUL_LAT+1.
  - c=MUL_LAT+2, ADD0: add_a=p0, add_b=p1.
  - AWAIT0: sum captured from add_q at c=MUL_LAT+2+ADD_LAT.
  - c=MUL_LAT+3+ADD_LAT, ADD1: add_a=sum, add_b=bias.
  - AWAIT1, then STORE at c=T-1: add_q passes through ReLU and is written to slot k. ReLU rule: sign bit 1 → 32'h0, otherwise pass unchanged (-0.0 → 0).
  - Next cycle: MUL0 of neuron k+1. After the last neuron, state=IDLE and out_valid=1.
- FPU operands are 0 in every cycle with no issue (IDLE, wait states).
- A single cycle counter plus the neuron index drive all transitions; latencies are exact, with no FPU handshake.
- Output timing and hold:
  - out_valid rises exactly NEURONS*T edges after the acceptance edge.
  - out_data is stable while out_valid=1. It is not cleared on handoff; it holds the last results.
  - out_valid falls on the edge where out_ready=1.
  - in_ready rises the cycle after out_valid falls. Input and output never overlap.
- in_valid and x_in/y_in are ignored while in_ready=0.

Optional Feature:
- Macro: RELU_SEQ_ABORT_EN.
- Enabled: adds port abort (in, 1).
  - abort=1 while state≠IDLE → state=IDLE at the next edge.
  - Partial results are discarded, out_valid stays 0, out_data keeps its previous value.
  - In-flight FPU results are ignored.
  - abort in IDLE, or while out_valid=1, has no effect.
- Disabled: no port, no logic.

Test Plan:
1. Reset defaults, NEURONS=3, MUL_LAT=3, ADD_LAT=2, x=y=0x3f800000 → all three slots = 0x40E66667; out_valid rises exactly 33 edges after acceptance.
2. Write addr 5 (bias of neuron 1) = 0xC1200000 (-10.0), same inputs → slot1 = 0x00000000; slots 0 and 2 = 0x40E66667.
3. x=0x00000000, y=0x3f800000, wx=wy=bias=0x3F800000 for all neurons → all slots 0x40000000 (2.0).
4. Hold out_ready=0 for 20 cycles after out_valid → out_data stable, in_ready=0, in_valid ignored; out_ready=1 → out_valid falls, in_ready=1 the next cycle.
5. cfg write during busy, and cfg write to addr 9 while IDLE → cfg_err pulses one cycle each, register file unchanged, results unaffected.
6. Drive reset=0 at cycle 15 of a computation → all outputs are at reset values immediately; after release, weights read back as INIT_VAL through results (scenario 1 values); with RELU_SEQ_ABORT_EN, abort at cycle 10 → IDLE next cycle, out_valid never asserts.
